// File: rtl/pipelined_control_unit_if.sv
// Bus between the pipeline datapath and its control unit.
// The datapath (master) supplies the ID fields and branch outcome and consumes the per-stage control.
interface pipelined_control_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [6:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              ex_flush;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;

    logic              ex_ALUSrc;
    logic              ex_Branch;
    logic              ex_Jump;
    logic              ex_MemRead;
    logic              ex_MemWrite;
    logic              ex_RegWrite;
    logic [1:0]        ex_ALUOp;
    logic [1:0]        ex_ResultSrc;
    logic [REG_AW-1:0] ex_rd;

    logic              mem_MemRead;
    logic              mem_MemWrite;
    logic              mem_RegWrite;
    logic [1:0]        mem_ResultSrc;
    logic [REG_AW-1:0] mem_rd;

    logic              wb_RegWrite;
    logic [1:0]        wb_ResultSrc;
    logic [REG_AW-1:0] wb_rd;

    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_opcode, id_rs1, id_rs2, id_rd, ex_flush,
        input  pc_write, ifid_write, ifid_flush,
        input  ex_ALUSrc, ex_Branch, ex_Jump, ex_MemRead, ex_MemWrite, ex_RegWrite,
        input  ex_ALUOp, ex_ResultSrc, ex_rd,
        input  mem_MemRead, mem_MemWrite, mem_RegWrite, mem_ResultSrc, mem_rd,
        input  wb_RegWrite, wb_ResultSrc, wb_rd,
        input  fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, id_rd, ex_flush,
        output pc_write, ifid_write, ifid_flush,
        output ex_ALUSrc, ex_Branch, ex_Jump, ex_MemRead, ex_MemWrite, ex_RegWrite,
        output ex_ALUOp, ex_ResultSrc, ex_rd,
        output mem_MemRead, mem_MemWrite, mem_RegWrite, mem_ResultSrc, mem_rd,
        output wb_RegWrite, wb_ResultSrc, wb_rd,
        output fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Control unit for a 5-stage RISC-V pipeline: decode, ID/EX..MEM/WB control registers,
// load-use stall, branch/jump flush, EX operand forwarding and a saturating stall counter.
module pipelined_control_unit #(
    parameter int REG_AW     = 5,
    parameter int ENABLE_EXT = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipelined_control_unit_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic              alu_src;
        logic              branch;
        logic              jump;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [1:0]        alu_op;
        logic [1:0]        result_src;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } ex_bundle_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [1:0]        result_src;
        logic [REG_AW-1:0] rd;
    } mem_bundle_t;

    typedef struct packed {
        logic              reg_write;
        logic [1:0]        result_src;
        logic [REG_AW-1:0] rd;
    } wb_bundle_t;

    ex_bundle_t       id_dec;
    logic             id_valid;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             load_use;
    logic             stall;

    ex_bundle_t       ex_stage_reg,  ex_stage_next;
    mem_bundle_t      mem_stage_reg, mem_stage_next;
    wb_bundle_t       wb_stage_reg,  wb_stage_next;
    logic [CNT_W-1:0] stall_count_reg, stall_count_next;

    // Decode; unknown opcodes (and EXT opcodes when disabled) yield an all-zero NOP bundle.
    always_comb begin
        id_dec   = '0;
        id_valid = 1'b1;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (bus.id_opcode)
            OP_R: begin
                id_dec.reg_write = 1'b1;
                id_dec.alu_op    = 2'b10;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
            end
            OP_I: begin
                id_dec.alu_src   = 1'b1;
                id_dec.reg_write = 1'b1;
                id_dec.alu_op    = 2'b10;
                uses_rs1         = 1'b1;
            end
            OP_LW: begin
                id_dec.alu_src    = 1'b1;
                id_dec.mem_read   = 1'b1;
                id_dec.reg_write  = 1'b1;
                id_dec.result_src = 2'b01;
                uses_rs1          = 1'b1;
            end
            OP_SW: begin
                id_dec.alu_src   = 1'b1;
                id_dec.mem_write = 1'b1;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
            end
            OP_BR: begin
                id_dec.branch = 1'b1;
                id_dec.alu_op = 2'b01;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_JAL: begin
                id_dec.jump       = 1'b1;
                id_dec.reg_write  = 1'b1;
                id_dec.result_src = 2'b10;
                id_valid          = (ENABLE_EXT != 0);
            end
            OP_JALR: begin
                id_dec.jump       = 1'b1;
                id_dec.alu_src    = 1'b1;
                id_dec.reg_write  = 1'b1;
                id_dec.result_src = 2'b10;
                uses_rs1          = (ENABLE_EXT != 0);
                id_valid          = (ENABLE_EXT != 0);
            end
            OP_LUI: begin
                id_dec.alu_src   = 1'b1;
                id_dec.reg_write = 1'b1;
                id_dec.alu_op    = 2'b11;
                id_valid         = (ENABLE_EXT != 0);
            end
            OP_AUIPC: begin
                id_dec.alu_src   = 1'b1;
                id_dec.reg_write = 1'b1;
                id_dec.alu_op    = 2'b00;
                id_valid         = (ENABLE_EXT != 0);
            end
            default: id_valid = 1'b0;
        endcase
        id_dec.rd  = bus.id_rd;
        id_dec.rs1 = bus.id_rs1;
        id_dec.rs2 = bus.id_rs2;
        if (bus.id_rd == '0) begin
            id_dec.reg_write = 1'b0;
        end
        if (!id_valid) begin
            id_dec = '0;
        end
    end

    assign load_use = ex_stage_reg.mem_read && (ex_stage_reg.rd != '0) &&
                      ((uses_rs1 && (ex_stage_reg.rd == bus.id_rs1)) ||
                       (uses_rs2 && (ex_stage_reg.rd == bus.id_rs2)));

    // A taken branch/jump discards the stalled instruction anyway, so flush wins.
    assign stall = load_use && !bus.ex_flush;

    assign bus.pc_write   = !stall;
    assign bus.ifid_write = !stall;
    assign bus.ifid_flush = bus.ex_flush;

    always_comb begin
        ex_stage_next = id_dec;
        if (load_use || bus.ex_flush) begin
            ex_stage_next = '0;
        end

        mem_stage_next.mem_read   = ex_stage_reg.mem_read;
        mem_stage_next.mem_write  = ex_stage_reg.mem_write;
        mem_stage_next.reg_write  = ex_stage_reg.reg_write;
        mem_stage_next.result_src = ex_stage_reg.result_src;
        mem_stage_next.rd         = ex_stage_reg.rd;

        wb_stage_next.reg_write  = mem_stage_reg.reg_write;
        wb_stage_next.result_src = mem_stage_reg.result_src;
        wb_stage_next.rd         = mem_stage_reg.rd;

        stall_count_next = stall_count_reg;
        if (stall && (stall_count_reg != '1)) begin
            stall_count_next = stall_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_stage_reg    <= '0;
            mem_stage_reg   <= '0;
            wb_stage_reg    <= '0;
            stall_count_reg <= '0;
        end else begin
            ex_stage_reg    <= ex_stage_next;
            mem_stage_reg   <= mem_stage_next;
            wb_stage_reg    <= wb_stage_next;
            stall_count_reg <= stall_count_next;
        end
    end

    // Per-operand forwarding: the younger MEM result beats the older WB result.
    logic [REG_AW-1:0] ex_rs   [2];
    logic [1:0]        fwd_sel [2];

    assign ex_rs[0] = ex_stage_reg.rs1;
    assign ex_rs[1] = ex_stage_reg.rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic mem_hit;
            logic wb_hit;
            assign mem_hit = mem_stage_reg.reg_write && (mem_stage_reg.rd != '0) &&
                             (mem_stage_reg.rd == ex_rs[gi]);
            assign wb_hit  = wb_stage_reg.reg_write && (wb_stage_reg.rd != '0) &&
                             (wb_stage_reg.rd == ex_rs[gi]);
            assign fwd_sel[gi] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
        end
    endgenerate

    assign bus.fwd_a = fwd_sel[0];
    assign bus.fwd_b = fwd_sel[1];

    assign bus.ex_ALUSrc    = ex_stage_reg.alu_src;
    assign bus.ex_Branch    = ex_stage_reg.branch;
    assign bus.ex_Jump      = ex_stage_reg.jump;
    assign bus.ex_MemRead   = ex_stage_reg.mem_read;
    assign bus.ex_MemWrite  = ex_stage_reg.mem_write;
    assign bus.ex_RegWrite  = ex_stage_reg.reg_write;
    assign bus.ex_ALUOp     = ex_stage_reg.alu_op;
    assign bus.ex_ResultSrc = ex_stage_reg.result_src;
    assign bus.ex_rd        = ex_stage_reg.rd;

    assign bus.mem_MemRead   = mem_stage_reg.mem_read;
    assign bus.mem_MemWrite  = mem_stage_reg.mem_write;
    assign bus.mem_RegWrite  = mem_stage_reg.reg_write;
    assign bus.mem_ResultSrc = mem_stage_reg.result_src;
    assign bus.mem_rd        = mem_stage_reg.rd;

    assign bus.wb_RegWrite  = wb_stage_reg.reg_write;
    assign bus.wb_ResultSrc = wb_stage_reg.result_src;
    assign bus.wb_rd        = wb_stage_reg.rd;

    assign bus.stall_count = stall_count_reg;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: one main instance plus an EXT-disabled instance and a 2-bit stall-counter
// instance, all driven with the same ID stimulus.
module tb_pipelined_control_unit;
    localparam logic [6:0] OP_NOP = 7'b0000000;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = OP_NOP;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       flush = 1'b0;
    int         tests_run = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    pipelined_control_unit_if #(.REG_AW(5), .CNT_W(16)) bus_main ();
    pipelined_control_unit_if #(.REG_AW(5), .CNT_W(16)) bus_noext ();
    pipelined_control_unit_if #(.REG_AW(5), .CNT_W(2))  bus_sat ();

    assign bus_main.id_opcode  = opcode;  assign bus_main.id_rs1  = rs1;  assign bus_main.id_rs2  = rs2;
    assign bus_main.id_rd      = rd;      assign bus_main.ex_flush  = flush;
    assign bus_noext.id_opcode = opcode;  assign bus_noext.id_rs1 = rs1;  assign bus_noext.id_rs2 = rs2;
    assign bus_noext.id_rd     = rd;      assign bus_noext.ex_flush = flush;
    assign bus_sat.id_opcode   = opcode;  assign bus_sat.id_rs1   = rs1;  assign bus_sat.id_rs2   = rs2;
    assign bus_sat.id_rd       = rd;      assign bus_sat.ex_flush   = flush;

    pipelined_control_unit #(.REG_AW(5), .ENABLE_EXT(1), .CNT_W(16)) dut_main (
        .clk(clk), .reset(reset), .bus(bus_main));
    pipelined_control_unit #(.REG_AW(5), .ENABLE_EXT(0), .CNT_W(16)) dut_noext (
        .clk(clk), .reset(reset), .bus(bus_noext));
    pipelined_control_unit #(.REG_AW(5), .ENABLE_EXT(1), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus_sat));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d);
        opcode = op; rs1 = s1; rs2 = s2; rd = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        tests_run++; if (bus_main.ex_RegWrite !== 1'b0) begin tests_failed++; $display("FAIL reset_ex_regwrite got %0b expected 0", bus_main.ex_RegWrite); end
        tests_run++; if (bus_main.stall_count !== 16'd0) begin tests_failed++; $display("FAIL reset_stall_count got %0d expected 0", bus_main.stall_count); end
        tests_run++; if ({bus_main.pc_write, bus_main.ifid_write, bus_main.ifid_flush} !== 3'b110) begin tests_failed++; $display("FAIL reset_pc_ifid got %b expected 110", {bus_main.pc_write, bus_main.ifid_write, bus_main.ifid_flush}); end
        tests_run++; if ({bus_main.fwd_a, bus_main.fwd_b} !== 4'b0000) begin tests_failed++; $display("FAIL reset_fwd got %b expected 0000", {bus_main.fwd_a, bus_main.fwd_b}); end
        $display("[TB] reset: checked idle outputs");
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_propagation();
        set_id(OP_R, 5'd1, 5'd2, 5'd3); tick();
        tests_run++; if ({bus_main.ex_RegWrite, bus_main.ex_ALUOp, bus_main.ex_rd} !== {1'b1, 2'b10, 5'd3}) begin tests_failed++; $display("FAIL prop_ex got %b expected 1_10_00011", {bus_main.ex_RegWrite, bus_main.ex_ALUOp, bus_main.ex_rd}); end
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0); tick();
        tests_run++; if ({bus_main.mem_RegWrite, bus_main.mem_rd} !== {1'b1, 5'd3}) begin tests_failed++; $display("FAIL prop_mem got %b expected 1_00011", {bus_main.mem_RegWrite, bus_main.mem_rd}); end
        tests_run++; if (bus_main.ex_RegWrite !== 1'b0) begin tests_failed++; $display("FAIL prop_ex_nop got %0b expected 0", bus_main.ex_RegWrite); end
        tick();
        tests_run++; if ({bus_main.wb_RegWrite, bus_main.wb_rd} !== {1'b1, 5'd3}) begin tests_failed++; $display("FAIL prop_wb got %b expected 1_00011", {bus_main.wb_RegWrite, bus_main.wb_rd}); end
        set_id(OP_R, 5'd1, 5'd2, 5'd0); tick();
        tests_run++; if (bus_main.ex_RegWrite !== 1'b0) begin tests_failed++; $display("FAIL prop_rd0_ex got %0b expected 0", bus_main.ex_RegWrite); end
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0); tick();
        tests_run++; if (bus_main.mem_RegWrite !== 1'b0) begin tests_failed++; $display("FAIL prop_rd0_mem got %0b expected 0", bus_main.mem_RegWrite); end
        tick();
        tests_run++; if (bus_main.wb_RegWrite !== 1'b0) begin tests_failed++; $display("FAIL prop_rd0_wb got %0b expected 0", bus_main.wb_RegWrite); end
        $display("[TB] propagation: R rd=3 and rd=0 through EX/MEM/WB");
    endtask

    task automatic test_load_use();
        set_id(OP_LW, 5'd1, 5'd0, 5'd5); tick();
        tests_run++; if ({bus_main.ex_MemRead, bus_main.ex_ResultSrc} !== 3'b101) begin tests_failed++; $display("FAIL lu_ex_lw got %b expected 101", {bus_main.ex_MemRead, bus_main.ex_ResultSrc}); end
        set_id(OP_R, 5'd5, 5'd6, 5'd8); #1;
        tests_run++; if ({bus_main.pc_write, bus_main.ifid_write, bus_main.ifid_flush} !== 3'b000) begin tests_failed++; $display("FAIL lu_stall got %b expected 000", {bus_main.pc_write, bus_main.ifid_write, bus_main.ifid_flush}); end
        tick();
        tests_run++; if ({bus_main.ex_MemRead, bus_main.ex_RegWrite, bus_main.ex_rd} !== 7'd0) begin tests_failed++; $display("FAIL lu_bubble got %b expected 0000000", {bus_main.ex_MemRead, bus_main.ex_RegWrite, bus_main.ex_rd}); end
        tests_run++; if ({bus_main.pc_write, bus_main.ifid_write} !== 2'b11) begin tests_failed++; $display("FAIL lu_one_cycle got %b expected 11", {bus_main.pc_write, bus_main.ifid_write}); end
        tests_run++; if (bus_main.stall_count !== 16'd1) begin tests_failed++; $display("FAIL lu_count got %0d expected 1", bus_main.stall_count); end
        tests_run++; if (bus_main.mem_MemRead !== 1'b1) begin tests_failed++; $display("FAIL lu_mem_lw got %0b expected 1", bus_main.mem_MemRead); end
        tick();
        tests_run++; if ({bus_main.ex_RegWrite, bus_main.ex_rd} !== {1'b1, 5'd8}) begin tests_failed++; $display("FAIL lu_resume got %b expected 1_01000", {bus_main.ex_RegWrite, bus_main.ex_rd}); end
        tests_run++; if ({bus_main.fwd_a, bus_main.fwd_b} !== 4'b0100) begin tests_failed++; $display("FAIL lu_fwd_wb got %b expected 0100", {bus_main.fwd_a, bus_main.fwd_b}); end
        $display("[TB] load_use: LW rd=5 then R rs1=5 stalled once");

        set_id(OP_LW, 5'd1, 5'd0, 5'd0); tick();
        set_id(OP_R, 5'd0, 5'd0, 5'd8); #1;
        tests_run++; if (bus_main.pc_write !== 1'b1) begin tests_failed++; $display("FAIL lu_rd0_nostall got %0b expected 1", bus_main.pc_write); end
        tick();
        tests_run++; if (bus_main.stall_count !== 16'd1) begin tests_failed++; $display("FAIL lu_rd0_count got %0d expected 1", bus_main.stall_count); end
        $display("[TB] load_use: LW rd=0 caused no stall");

        set_id(OP_LW, 5'd1, 5'd0, 5'd5); tick();
        set_id(OP_I, 5'd1, 5'd5, 5'd9); #1;
        tests_run++; if (bus_main.pc_write !== 1'b1) begin tests_failed++; $display("FAIL lu_rs2_unused got %0b expected 1", bus_main.pc_write); end
        tick();
        tests_run++; if ({bus_main.ex_RegWrite, bus_main.ex_ALUSrc, bus_main.ex_rd} !== {2'b11, 5'd9}) begin tests_failed++; $display("FAIL lu_itype_ex got %b expected 11_01001", {bus_main.ex_RegWrite, bus_main.ex_ALUSrc, bus_main.ex_rd}); end
        $display("[TB] load_use: I-type with unused rs2=5 caused no stall");
    endtask

    task automatic test_flush();
        set_id(OP_LW, 5'd1, 5'd0, 5'd5); tick();
        set_id(OP_R, 5'd5, 5'd0, 5'd4); flush = 1'b1; #1;
        tests_run++; if ({bus_main.pc_write, bus_main.ifid_write, bus_main.ifid_flush} !== 3'b111) begin tests_failed++; $display("FAIL flush_ctrl got %b expected 111", {bus_main.pc_write, bus_main.ifid_write, bus_main.ifid_flush}); end
        tick();
        flush = 1'b0;
        tests_run++; if ({bus_main.ex_RegWrite, bus_main.ex_rd} !== 6'd0) begin tests_failed++; $display("FAIL flush_bubble got %b expected 000000", {bus_main.ex_RegWrite, bus_main.ex_rd}); end
        tests_run++; if (bus_main.stall_count !== 16'd1) begin tests_failed++; $display("FAIL flush_count got %0d expected 1", bus_main.stall_count); end
        $display("[TB] flush: flush beat load-use, no stall counted");
    endtask

    task automatic test_forwarding();
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0); tick(); tick(); tick();
        set_id(OP_R, 5'd0, 5'd0, 5'd7); tick();
        set_id(OP_R, 5'd0, 5'd0, 5'd7); tick();
        set_id(OP_R, 5'd7, 5'd7, 5'd1); tick();
        tests_run++; if ({bus_main.fwd_a, bus_main.fwd_b} !== 4'b1010) begin tests_failed++; $display("FAIL fwd_mem_prio got %b expected 1010", {bus_main.fwd_a, bus_main.fwd_b}); end
        set_id(OP_R, 5'd0, 5'd0, 5'd7); tick();
        set_id(OP_I, 5'd0, 5'd0, 5'd2); tick();
        set_id(OP_R, 5'd7, 5'd7, 5'd1); tick();
        tests_run++; if ({bus_main.fwd_a, bus_main.fwd_b} !== 4'b0101) begin tests_failed++; $display("FAIL fwd_wb_only got %b expected 0101", {bus_main.fwd_a, bus_main.fwd_b}); end
        set_id(OP_R, 5'd0, 5'd0, 5'd0); tick();
        set_id(OP_R, 5'd0, 5'd0, 5'd3); tick();
        tests_run++; if ({bus_main.fwd_a, bus_main.fwd_b} !== 4'b0000) begin tests_failed++; $display("FAIL fwd_x0 got %b expected 0000", {bus_main.fwd_a, bus_main.fwd_b}); end
        $display("[TB] forwarding: MEM priority, WB only, x0 never forwarded");
    endtask

    task automatic test_ext();
        set_id(OP_JAL, 5'd0, 5'd0, 5'd1); tick();
        tests_run++; if ({bus_main.ex_Jump, bus_main.ex_RegWrite, bus_main.ex_ResultSrc} !== 4'b1110) begin tests_failed++; $display("FAIL ext_jal_on got %b expected 1110", {bus_main.ex_Jump, bus_main.ex_RegWrite, bus_main.ex_ResultSrc}); end
        tests_run++; if ({bus_noext.ex_Jump, bus_noext.ex_RegWrite, bus_noext.ex_ResultSrc, bus_noext.ex_rd} !== 9'd0) begin tests_failed++; $display("FAIL ext_jal_off got %b expected 000000000", {bus_noext.ex_Jump, bus_noext.ex_RegWrite, bus_noext.ex_ResultSrc, bus_noext.ex_rd}); end
        set_id(OP_LUI, 5'd0, 5'd0, 5'd4); tick();
        tests_run++; if ({bus_main.ex_ALUSrc, bus_main.ex_ALUOp} !== 3'b111) begin tests_failed++; $display("FAIL ext_lui got %b expected 111", {bus_main.ex_ALUSrc, bus_main.ex_ALUOp}); end
        $display("[TB] ext: JAL/LUI decoded only with ENABLE_EXT=1");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            set_id(OP_LW, 5'd1, 5'd0, 5'd5); tick();
            set_id(OP_R, 5'd5, 5'd0, 5'd6); tick();
        end
        tests_run++; if (bus_main.stall_count !== 16'd6) begin tests_failed++; $display("FAIL sat_main_count got %0d expected 6", bus_main.stall_count); end
        tests_run++; if (bus_sat.stall_count !== 2'd3) begin tests_failed++; $display("FAIL sat_hold got %0d expected 3", bus_sat.stall_count); end
        $display("[TB] saturation: 5 more stalls, 2-bit counter held at 3");
    endtask

    task automatic test_async_reset();
        set_id(OP_LW, 5'd1, 5'd0, 5'd2); tick();
        set_id(OP_LW, 5'd1, 5'd0, 5'd5); tick();
        set_id(OP_R, 5'd5, 5'd0, 5'd6); #1;
        tests_run++; if ({bus_main.pc_write, bus_main.ex_MemRead, bus_main.mem_MemRead} !== 3'b011) begin tests_failed++; $display("FAIL ar_pre got %b expected 011", {bus_main.pc_write, bus_main.ex_MemRead, bus_main.mem_MemRead}); end
        reset = 1'b0; #1;
        tests_run++; if ({bus_main.ex_MemRead, bus_main.mem_MemRead, bus_main.mem_RegWrite, bus_main.wb_RegWrite, bus_main.mem_rd} !== 9'd0) begin tests_failed++; $display("FAIL ar_clear got %b expected 000000000", {bus_main.ex_MemRead, bus_main.mem_MemRead, bus_main.mem_RegWrite, bus_main.wb_RegWrite, bus_main.mem_rd}); end
        tests_run++; if (bus_main.stall_count !== 16'd0 || bus_sat.stall_count !== 2'd0) begin tests_failed++; $display("FAIL ar_count got %0d/%0d expected 0/0", bus_main.stall_count, bus_sat.stall_count); end
        tests_run++; if ({bus_main.pc_write, bus_main.ifid_write, bus_main.ifid_flush} !== 3'b110) begin tests_failed++; $display("FAIL ar_ctrl got %b expected 110", {bus_main.pc_write, bus_main.ifid_write, bus_main.ifid_flush}); end
        $display("[TB] async_reset: mid-stall reset cleared stages immediately");
        @(negedge clk);
        set_id(OP_NOP, 5'd0, 5'd0, 5'd0);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_propagation();
        test_load_use();
        test_flush();
        test_forwarding();
        test_ext();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation control unit for the 5-stage RISC-V pipeline.
- Decodes the ID-stage opcode into per-stage control bundles and carries them through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall plus bubble) and applies branch/jump flushes.
- Generates EX-stage forwarding selects and keeps a saturating stall counter.

Parameters:
- REG_AW, 5, register-address width.
- ENABLE_EXT, 1, when 1 decode JAL/JALR/LUI/AUIPC; when 0 those opcodes decode as NOP.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_opcode  in  7  opcode of instruction in ID.
- id_rs1, id_rs2, id_rd  in  REG_AW  ID register fields.
- ex_flush  in  1  branch/jump resolved taken in EX this cycle.
- pc_write, ifid_write  out  1  enables for PC and IF/ID registers.
- ifid_flush  out  1  clear IF/ID to NOP.
- ex_ALUSrc, ex_Branch, ex_Jump, ex_MemRead, ex_MemWrite, ex_RegWrite  out  1  EX-stage control.
- ex_ALUOp  out  2  00 add, 01 branch compare, 10 R/I funct decode, 11 pass operand B (LUI).
- ex_ResultSrc, mem_ResultSrc, wb_ResultSrc  out  2  00 ALU, 01 memory, 10 PC+4.
- ex_rd, mem_rd, wb_rd  out  REG_AW  destination register per stage.
- mem_MemRead, mem_MemWrite, mem_RegWrite, wb_RegWrite  out  1  later-stage control.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 WB, 10 MEM.
- stall_count  out  CNT_W  load-use stall cycles since reset.

Behaviour:
- Decode (combinational from id_opcode):
  - R 0110011: RegWrite, ALUOp 10.
  - I 0010011: ALUSrc, RegWrite, ALUOp 10.
  - LW 0000011: ALUSrc, MemRead, RegWrite, ResultSrc 01.
  - SW 0100011: ALUSrc, MemWrite.
  - BR 1100011: Branch, ALUOp 01.
  - JAL 1101111: Jump, RegWrite, ResultSrc 10.
  - JALR 1100111: Jump, ALUSrc, RegWrite, ResultSrc 10.
  - LUI 0110111: ALUSrc, RegWrite, ALUOp 11.
  - AUIPC 0010111: ALUSrc, RegWrite, ALUOp 00.
  - Any other opcode, or an EXT opcode with ENABLE_EXT=0: all zero (NOP).
  - RegWrite is forced to 0 when id_rd==0.
- Operand use:
  - rs1 is used by R, I, LW, SW, BR, JALR.
  - rs2 is used by R, SW, BR.
- Load-use hazard: load_use = ex_MemRead & ex_rd!=0 & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- Pipeline registers:
  - Each rising edge: MEM<=EX, WB<=MEM.
  - EX<=decoded ID bundle (including id_rs1/id_rs2, held internally for forwarding), or a bubble (all-zero) when load_use or ex_flush.
- Stall (load_use & !ex_flush):
  - pc_write=0, ifid_write=0 combinationally in the same cycle.
  - Exactly one bubble is inserted.
  - stall_count increments, saturating at all-ones.
- Flush (ex_flush):
  - ifid_flush=1, pc_write=1, ifid_write=1.
  - EX receives a bubble.
  - Flush has priority over stall; no stall is counted.
- Idle: pc_write=1, ifid_write=1, ifid_flush=0.
- Forwarding (per operand, using ex_rs1/ex_rs2):
  - 10 if mem_RegWrite & mem_rd!=0 & mem_rd==ex_rsX.
  - Else 01 if wb_RegWrite & wb_rd!=0 & wb_rd==ex_rsX.
  - Else 00. MEM has priority over WB.
- Reset (asserted low, asynchronous, including mid-stall):
  - All stage registers clear to bubble; all ex_/mem_/wb_ outputs = 0; fwd_a = fwd_b = 00; stall_count = 0.
  - pc_write, ifid_write and ifid_flush follow the combinational rules, so they read 1/1/0.
- Latency: ID decode appears on ex_ outputs 1 cycle later, mem_ 2 cycles, wb_ 3 cycles.

Test Plan:
- Reset: LW in EX, pull reset low between edges -> ex_MemRead, mem_*, wb_* drop to 0 immediately; stall_count=0.
- Propagation: ID opcode 0110011 rd=3 -> after edge 1 ex_RegWrite=1, ex_ALUOp=10, ex_rd=3; after edge 2 mem_RegWrite=1, mem_rd=3; after edge 3 wb_RegWrite=1, wb_rd=3. Same with rd=0 -> RegWrite 0 in every stage.
- Load-use: EX=LW rd=5, ID=R-type rs1=5 -> pc_write=0 and ifid_write=0 for exactly one cycle; next EX all zero; stall_count 0->1. Repeat with EX LW rd=0 -> no stall. Repeat with ID=I-type rs2=5 (rs2 unused) -> no stall.
- Flush vs stall: load_use and ex_flush in the same cycle -> ifid_flush=1, pc_write=1, EX bubble, stall_count unchanged.
- Forwarding: mem_rd=7 and wb_rd=7, both RegWrite, ex_rs1=7, ex_rs2=7 -> fwd_a=10, fwd_b=10. With only wb_rd=7 -> 01. With mem_rd=0 and ex_rs1=0 -> 00.
- Mode and saturation: ENABLE_EXT=0 with opcode 1101111 -> all-zero EX bundle; ENABLE_EXT=1 -> ex_Jump=1, ex_ResultSrc=10. With CNT_W=2, 5 stalls -> stall_count holds at 3.
